// File: rtl/cache_controller.sv
// Direct-mapped write-through / no-write-allocate data cache sequencer between the core's load-store path and data_memory.
// Latency: read hit 0 cycles; read miss = ack latency + 1 stalled cycles then RESP; store = ack latency + 1 stalled cycles then RESP.
// Backpressure: stall holds the core (PC, request, regfile write) for the whole access; mem_req is held until mem_ack.
module cache_controller #(
  parameter int INDEX_BITS = 4,
  parameter int CNT_W      = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cpu_read,
  input  logic             cpu_write,
  input  logic [31:0]      cpu_addr,
  input  logic [31:0]      cpu_wdata,
  output logic [31:0]      cpu_rdata,
  output logic             stall,
  output logic             hit,
  output logic             miss,
  output logic             mem_req,
  output logic             mem_we,
  output logic [31:0]      mem_addr,
  output logic [31:0]      mem_wdata,
  input  logic             mem_ack,
  input  logic [31:0]      mem_rdata,
  output logic [CNT_W-1:0] hit_count,
  output logic [CNT_W-1:0] miss_count
);

  localparam int LINES = 2 ** INDEX_BITS;
  localparam int TAG_W = 32 - INDEX_BITS - 2;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FILL  = 2'd1,
    WRITE = 2'd2,
    RESP  = 2'd3
  } state_t;

  state_t                  state;
  logic [LINES-1:0]        valid;
  logic [TAG_W-1:0]        tag_array  [LINES];
  logic [31:0]             data_array [LINES];
  logic                    resp_read;   // RESP returns data only for loads

  logic [INDEX_BITS-1:0]   index;
  logic [TAG_W-1:0]        tag;
  logic                    lookup_hit;
  logic                    line_we;
  logic                    tag_we;
  logic [31:0]             line_wdata;

  // The core holds its request for the whole access, so the address fields
  // stay valid in FILL/WRITE/RESP without capturing them.
  assign index      = cpu_addr[INDEX_BITS+1:2];
  assign tag        = cpu_addr[31:INDEX_BITS+2];
  assign lookup_hit = valid[index] && (tag_array[index] == tag);
  // Masking keeps the word-aligned address without leaving bits [1:0] dangling.
  assign mem_addr   = cpu_addr & 32'hFFFF_FFFC;
  assign mem_wdata  = cpu_wdata;

  // Array write strobes: store hits update in place, fills write data and tag.
  always_comb begin
    line_we    = 1'b0;
    tag_we     = 1'b0;
    line_wdata = cpu_wdata;
    if (!reset) begin
      if (state == IDLE && cpu_write && lookup_hit) begin
        line_we = 1'b1;
      end else if (state == FILL && mem_ack) begin
        line_we    = 1'b1;
        tag_we     = 1'b1;
        line_wdata = mem_rdata;
      end
    end
  end

  // Tag and data storage; no reset because valid gates every use.
  always_ff @(posedge clk) begin
    if (line_we) data_array[index] <= line_wdata;
    if (tag_we)  tag_array[index]  <= tag;
  end

  // Access sequencer, valid bits and saturating hit/miss counters.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      valid      <= '0;
      hit_count  <= '0;
      miss_count <= '0;
      resp_read  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (cpu_write || cpu_read) begin
            if (lookup_hit) begin
              if (hit_count != CNT_MAX) hit_count <= hit_count + 1'b1;
            end else begin
              if (miss_count != CNT_MAX) miss_count <= miss_count + 1'b1;
            end
          end
          if (cpu_write) begin
            // Store wins over a simultaneous load.
            resp_read <= 1'b0;
            state     <= WRITE;
          end else if (cpu_read) begin
            resp_read <= 1'b1;
            if (!lookup_hit) state <= FILL;
          end
        end
        FILL: begin
          if (mem_ack) begin
            valid[index] <= 1'b1;
            state        <= RESP;
          end
        end
        WRITE: begin
          // No allocation on a store miss: only the memory write completes.
          if (mem_ack) state <= RESP;
        end
        RESP: begin
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Core- and memory-facing handshake outputs, decoded from state and request.
  always_comb begin
    stall     = 1'b0;
    hit       = 1'b0;
    miss      = 1'b0;
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    cpu_rdata = 32'h0;
    if (!reset) begin
      case (state)
        IDLE: begin
          if (cpu_write) begin
            hit   = lookup_hit;
            miss  = ~lookup_hit;
            stall = 1'b1;
          end else if (cpu_read) begin
            hit   = lookup_hit;
            miss  = ~lookup_hit;
            stall = ~lookup_hit;
            if (lookup_hit) cpu_rdata = data_array[index];
          end
        end
        FILL: begin
          mem_req = 1'b1;
          stall   = 1'b1;
        end
        WRITE: begin
          mem_req = 1'b1;
          mem_we  = 1'b1;
          stall   = 1'b1;
        end
        RESP: begin
          if (resp_read) cpu_rdata = data_array[index];
        end
        default: begin
          stall = 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cache_controller.sv
// Directed bench for cache_controller with a variable-latency memory driven from the stimulus.
// Load results are queued when a load is issued and compared when the cache returns data.
// A second instance with 4-bit counters shares all inputs to exercise counter saturation.
module tb_cache_controller;

  logic        clk = 1'b0;
  logic        reset;
  logic        cpu_read;
  logic        cpu_write;
  logic [31:0] cpu_addr;
  logic [31:0] cpu_wdata;
  logic        mem_ack;
  logic [31:0] mem_rdata;

  logic [31:0] cpu_rdata;
  logic        stall, hit, miss, mem_req, mem_we;
  logic [31:0] mem_addr, mem_wdata;
  logic [15:0] hit_count, miss_count;

  logic [31:0] s_cpu_rdata;
  logic        s_stall, s_hit, s_miss, s_mem_req, s_mem_we;
  logic [31:0] s_mem_addr, s_mem_wdata;
  logic [3:0]  s_hit_count, s_miss_count;

  int checks   = 0;
  int failures = 0;
  logic [31:0] sb [$];

  always #5 clk = ~clk;

  cache_controller #(.INDEX_BITS(4), .CNT_W(16)) dut (
    .clk(clk), .reset(reset), .cpu_read(cpu_read), .cpu_write(cpu_write),
    .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata),
    .stall(stall), .hit(hit), .miss(miss), .mem_req(mem_req), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_ack(mem_ack),
    .mem_rdata(mem_rdata), .hit_count(hit_count), .miss_count(miss_count)
  );

  cache_controller #(.INDEX_BITS(4), .CNT_W(4)) dut4 (
    .clk(clk), .reset(reset), .cpu_read(cpu_read), .cpu_write(cpu_write),
    .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_rdata(s_cpu_rdata),
    .stall(s_stall), .hit(s_hit), .miss(s_miss), .mem_req(s_mem_req), .mem_we(s_mem_we),
    .mem_addr(s_mem_addr), .mem_wdata(s_mem_wdata), .mem_ack(mem_ack),
    .mem_rdata(mem_rdata), .hit_count(s_hit_count), .miss_count(s_miss_count)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic drop_request();
    cpu_read  = 1'b0;
    cpu_write = 1'b0;
  endtask

  // One core access. For a load, dat is the fill word on a miss or the
  // expected word on a hit; lat is the cycle of mem_req in which mem_ack fires.
  task automatic access(input bit rd, input bit wr, input logic [31:0] addr,
                        input logic [31:0] wd, input bit exp_hit, input int lat,
                        input logic [31:0] dat);
    int cyc;
    int stalls;
    bit done;
    logic [31:0] exp;
    cpu_read  = rd;
    cpu_write = wr;
    cpu_addr  = addr;
    cpu_wdata = wd;
    if (rd && !wr) sb.push_back(dat);
    @(negedge clk);
    check("lookup_hit", {31'b0, hit}, {31'b0, exp_hit});
    check("lookup_miss", {31'b0, miss}, {31'b0, !exp_hit});
    if (!wr && exp_hit) begin
      check("hit_no_stall", {31'b0, stall}, 32'd0);
      exp = sb.pop_front();
      check("hit_rdata", cpu_rdata, exp);
      @(posedge clk); #1;
      drop_request();
      return;
    end
    check("lookup_stall", {31'b0, stall}, 32'd1);
    stalls = 1;
    @(posedge clk); #1;
    cyc  = 0;
    done = 1'b0;
    while (!done && cyc < 100) begin
      cyc++;
      if (cyc == lat) begin
        mem_ack   = 1'b1;
        mem_rdata = dat;
      end
      @(negedge clk);
      if (cyc == 1) begin
        check("mem_req", {31'b0, mem_req}, 32'd1);
        check("mem_we", {31'b0, mem_we}, {31'b0, wr});
        check("mem_addr", mem_addr, {addr[31:2], 2'b00});
        if (wr) check("mem_wdata", mem_wdata, wd);
      end
      if (stall) stalls++;
      @(posedge clk); #1;
      mem_ack   = 1'b0;
      mem_rdata = 32'h0;
      if (cyc == lat) done = 1'b1;
    end
    check("ack_within_budget", {31'b0, done}, 32'd1);
    check("stall_cycles", stalls, lat + 1);
    @(negedge clk);
    check("resp_stall", {31'b0, stall}, 32'd0);
    check("resp_mem_req", {31'b0, mem_req}, 32'd0);
    if (!wr) begin
      exp = sb.pop_front();
      check("resp_rdata", cpu_rdata, exp);
    end
    @(posedge clk); #1;
    drop_request();
  endtask

  initial begin
    reset     = 1'b1;
    cpu_read  = 1'b1;
    cpu_write = 1'b0;
    cpu_addr  = 32'h40;
    cpu_wdata = 32'h0;
    mem_ack   = 1'b0;
    mem_rdata = 32'h0;

    // Outputs are forced quiet while reset is held, even with a request present.
    @(negedge clk);
    check("rst_stall", {31'b0, stall}, 32'd0);
    check("rst_mem_req", {31'b0, mem_req}, 32'd0);
    check("rst_hit", {31'b0, hit}, 32'd0);
    check("rst_miss", {31'b0, miss}, 32'd0);
    check("rst_rdata", cpu_rdata, 32'd0);
    @(posedge clk); #1;
    reset    = 1'b0;
    cpu_read = 1'b0;
    // A stray ack while idle must not start anything.
    mem_ack  = 1'b1;
    @(negedge clk);
    check("rst_hit_count", {16'b0, hit_count}, 32'd0);
    check("rst_miss_count", {16'b0, miss_count}, 32'd0);
    @(posedge clk); #1;
    mem_ack = 1'b0;
    @(negedge clk);
    check("idle_ack_ignored_req", {31'b0, mem_req}, 32'd0);
    check("idle_ack_ignored_stall", {31'b0, stall}, 32'd0);
    @(posedge clk); #1;

    // Read miss with 3-cycle memory, then same-cycle hit.
    access(1, 0, 32'h40, 32'h0, 0, 3, 32'h1234_5678);
    access(1, 0, 32'h40, 32'h0, 1, 0, 32'h1234_5678);

    // Store hit: write-through and in-place update.
    access(0, 1, 32'h40, 32'hA5A5_A5A5, 1, 2, 32'h0);
    access(1, 0, 32'h40, 32'h0, 1, 0, 32'hA5A5_A5A5);

    // Store miss: memory write only, so the following load still misses.
    access(0, 1, 32'h80, 32'h1111_2222, 0, 1, 32'h0);
    access(1, 0, 32'h80, 32'h0, 0, 2, 32'hCAFE_0080);

    // Index-0 conflict between 0x440 and 0x40.
    access(1, 0, 32'h440, 32'h0, 0, 1, 32'h0000_BEEF);
    access(1, 0, 32'h40, 32'h0, 0, 4, 32'hA5A5_A5A5);
    @(negedge clk);
    check("hit_count_a", {16'b0, hit_count}, 32'd3);
    check("miss_count_a", {16'b0, miss_count}, 32'd5);
    @(posedge clk); #1;

    // Reset lands in FILL together with mem_ack.
    cpu_read = 1'b1;
    cpu_addr = 32'h48;
    @(negedge clk);
    check("pre_reset_miss", {31'b0, miss}, 32'd1);
    @(posedge clk); #1;
    reset     = 1'b1;
    mem_ack   = 1'b1;
    mem_rdata = 32'hDEAD_0048;
    @(negedge clk);
    check("fill_rst_mem_req", {31'b0, mem_req}, 32'd0);
    check("fill_rst_stall", {31'b0, stall}, 32'd0);
    @(posedge clk); #1;
    reset     = 1'b0;
    mem_ack   = 1'b0;
    mem_rdata = 32'h0;
    cpu_read  = 1'b0;
    @(negedge clk);
    check("post_rst_mem_req", {31'b0, mem_req}, 32'd0);
    check("post_rst_hit_count", {16'b0, hit_count}, 32'd0);
    check("post_rst_miss_count", {16'b0, miss_count}, 32'd0);
    @(posedge clk); #1;
    access(1, 0, 32'h48, 32'h0, 0, 1, 32'h4848_4848);
    access(1, 0, 32'h40, 32'h0, 0, 2, 32'hA5A5_A5A5);
    access(1, 0, 32'h48, 32'h0, 1, 0, 32'h4848_4848);

    // Seventeen further hits: the 4-bit counter pins at 15.
    for (int i = 0; i < 17; i++) begin
      access(1, 0, 32'h48, 32'h0, 1, 0, 32'h4848_4848);
    end
    @(negedge clk);
    check("hit_count_b", {16'b0, hit_count}, 32'd18);
    check("miss_count_b", {16'b0, miss_count}, 32'd2);
    check("hit_count_sat", {28'b0, s_hit_count}, 32'd15);
    check("miss_count_small", {28'b0, s_miss_count}, 32'd2);
    @(posedge clk); #1;

    // Load and store together: handled as a store.
    access(1, 1, 32'h48, 32'h0BAD_F00D, 1, 2, 32'h0);
    access(1, 0, 32'h48, 32'h0, 1, 0, 32'h0BAD_F00D);
    @(negedge clk);
    check("hit_count_c", {16'b0, hit_count}, 32'd20);
    check("hit_count_sat_hold", {28'b0, s_hit_count}, 32'd15);
    check("scoreboard_drained", sb.size(), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
